// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC, the fetched-entry
// record and the PC fault check (also used by decode).
package fetch_unit_pkg;

  localparam logic [31:0] FETCH_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  localparam fetch_entry_t FETCH_EMPTY = '{pc: 32'h0, instr: FETCH_NOP, fault: 1'b0};

  // A PC is bad when it is not word aligned or lies beyond the ROM.
  function automatic logic pc_fault(input logic [31:0] pc, input logic [31:0] imem_words);
    return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= imem_words);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of fetch entries with push, pop and synchronous flush
// (flush wins). Presents a NOP entry at the head while empty.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   occ,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic [1:0]   occ_q;
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      occ_q  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: storage is not reset; occ_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign occ  = occ_q;
  assign head = (occ_q != 2'd0) ? mem[rd_ptr] : FETCH_EMPTY;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues synchronous ROM reads under a
// credit rule so the 2-entry skid buffer never overflows, and handles redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] pc_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  logic [31:0]  pc_q;
  logic [31:0]  inflight_pc;
  logic         inflight;
  logic [1:0]   occ;
  logic [2:0]   credit;
  logic         pop;
  logic         issue;
  fetch_entry_t head;
  fetch_entry_t push_entry;

  assign pop = out_valid & out_ready;

  // Words already held plus the one returning, minus the one leaving this cycle.
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue  = ~redirect_valid & (credit <= 3'd1);

  // NOTE: rst_n only gates the enable port so the ROM sees no read while reset is held;
  // it never reaches a flop data input.
  assign imem_en = rst_n & issue;
  assign pc_addr = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc_q;
        pc_q        <= pc_q + 32'd4;
      end
    end
  end

  assign push_entry = '{pc:    inflight_pc,
                        instr: imem_rdata,
                        fault: pc_fault(inflight_pc, 32'(IMEM_WORDS))};

  fetch_skid_buf u_skid_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .occ        (occ),
    .head       (head)
  );

  assign out_valid = (occ != 2'd0) & ~redirect_valid;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;
  assign out_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ROM returns the word index of the address,
// expected values are hand-derived per cycle and checked on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [31:0] pc_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(512)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_en        (imem_en),
    .pc_addr        (pc_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word index of the address; garbage when not enabled.
  always @(posedge clk) imem_rdata <= imem_en ? {21'b0, pc_addr[12:2]} : 32'hDEAD_BEEF;

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return {21'b0, pc[12:2]};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    total++; if (imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en: got %b want 0", imem_en); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    total++; if (out_instr !== 32'h0000_0013) begin bad++; $display("FAIL reset_instr: got %h want 00000013", out_instr); end
    total++; if (out_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", out_fault); end
    total++; if (pc_addr !== 32'h0) begin bad++; $display("FAIL reset_pc_addr: got %h want 0", pc_addr); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_c1_valid: got %b want 0", out_valid); end
    total++; if (imem_en !== 1'b1 || pc_addr !== 32'h4) begin bad++; $display("FAIL stream_c1_issue: got en=%b addr=%h want en=1 addr=4", imem_en, pc_addr); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== exp_instr(32'(4 * k)) || out_fault !== 1'b0) begin
        bad++; $display("FAIL stream_%0d: got v=%b pc=%h i=%h f=%b want v=1 pc=%h i=%h f=0",
                        k, out_valid, out_pc, out_instr, out_fault, 4 * k, exp_instr(32'(4 * k)));
      end
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'd20 || imem_en !== 1'b0 || pc_addr !== 32'd28) begin
        bad++; $display("FAIL stall_hold: got v=%b pc=%h en=%b addr=%h want v=1 pc=14 en=0 addr=1c",
                        out_valid, out_pc, imem_en, pc_addr);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'(20 + 4 * k) || out_instr !== exp_instr(32'(20 + 4 * k))) begin
        bad++; $display("FAIL stall_resume_%0d: got v=%b pc=%h i=%h want v=1 pc=%h",
                        k, out_valid, out_pc, out_instr, 20 + 4 * k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_flush;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || imem_en !== 1'b0) begin bad++; $display("FAIL flush_cycle: got v=%b en=%b want v=0 en=0", out_valid, imem_en); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || imem_en !== 1'b1 || pc_addr !== 32'h100) begin
      bad++; $display("FAIL flush_issue: got v=%b en=%b addr=%h want v=0 en=1 addr=100", out_valid, imem_en, pc_addr);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_gap: got v=%b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40 || out_fault !== 1'b0) begin
      bad++; $display("FAIL flush_target: got v=%b pc=%h i=%h f=%b want v=1 pc=100 i=40 f=0", out_valid, out_pc, out_instr, out_fault);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin bad++; $display("FAIL flush_next: got v=%b pc=%h want v=1 pc=104", out_valid, out_pc); end
  endtask

  task automatic test_redirect_pop;
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pop_suppressed: got v=%b want 0", out_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pop_gap: got v=%b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h102 || out_fault !== 1'b1 || out_instr !== 32'h40) begin
      bad++; $display("FAIL misaligned: got v=%b pc=%h i=%h f=%b want v=1 pc=102 i=40 f=1", out_valid, out_pc, out_instr, out_fault);
    end
    @(negedge clk);
    total++; if (out_pc !== 32'h106 || out_fault !== 1'b1 || out_instr !== 32'h41) begin
      bad++; $display("FAIL misaligned_next: got pc=%h i=%h f=%b want pc=106 i=41 f=1", out_pc, out_instr, out_fault);
    end
  endtask

  task automatic test_back_to_back;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h300) begin bad++; $display("FAIL b2b_last_wins: got v=%b pc=%h want v=1 pc=300", out_valid, out_pc); end
    @(negedge clk);
    total++; if (out_pc !== 32'h304) begin bad++; $display("FAIL b2b_next: got pc=%h want 304", out_pc); end
  endtask

  task automatic test_boundary;
    logic [31:0] pcs    [4] = '{32'h7F8, 32'h7FC, 32'h800, 32'h804};
    logic        faults [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    redirect_valid = 1'b1; redirect_pc = 32'h7F8;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_pc !== pcs[k] || out_fault !== faults[k] || out_instr !== exp_instr(pcs[k])) begin
        bad++; $display("FAIL range_%0d: got v=%b pc=%h i=%h f=%b want v=1 pc=%h i=%h f=%b",
                        k, out_valid, out_pc, out_instr, out_fault, pcs[k], exp_instr(pcs[k]), faults[k]);
      end
      @(negedge clk);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (out_pc !== 32'hFFFF_FFFC || out_fault !== 1'b1 || out_instr !== 32'h7FF) begin
      bad++; $display("FAIL top_pc: got pc=%h i=%h f=%b want pc=fffffffc i=7ff f=1", out_pc, out_instr, out_fault);
    end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_fault !== 1'b0) begin
      bad++; $display("FAIL wrap_pc: got v=%b pc=%h f=%b want v=1 pc=0 f=0", out_valid, out_pc, out_fault);
    end
  endtask

  task automatic test_async_reset;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || imem_en !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0000_0013 || out_fault !== 1'b0 || pc_addr !== 32'h0) begin
      bad++; $display("FAIL async_reset: got v=%b en=%b pc=%h i=%h f=%b addr=%h want v=0 en=0 pc=0 i=13 f=0 addr=0",
                      out_valid, imem_en, out_pc, out_instr, out_fault, pc_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rerun_c1: got v=%b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
      bad++; $display("FAIL rerun_first: got v=%b pc=%h i=%h want v=1 pc=0 i=0", out_valid, out_pc, out_instr);
    end
    @(negedge clk);
    total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL rerun_second: got pc=%h want 4", out_pc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_redirect_pop();
    test_back_to_back();
    test_boundary();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
